// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the sizing rule for the iteration counter.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold the value 2*bitwidth itself, hence the extra bit.
  function automatic int cnt_width(input int bitwidth);
    return $clog2(2 * bitwidth) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring division step: shift in the next dividend bit, try to subtract
// the divisor, keep the difference only if it did not go negative.
module seq_divider_div_step #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH:0]   partial_rem,
  input  logic                din_bit,
  input  logic [BITWIDTH-1:0] divisor,
  output logic [BITWIDTH:0]   new_rem,
  output logic                q_bit
);

  // One guard bit above the partial remainder carries the sign of the trial.
  logic [BITWIDTH+1:0] shifted;
  logic [BITWIDTH+1:0] trial;

  always_comb begin
    shifted = {partial_rem, din_bit};
    trial   = shifted - {2'b00, divisor};
    q_bit   = ~trial[BITWIDTH+1];
    new_rem = q_bit ? trial[BITWIDTH:0] : shifted[BITWIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both the operand and the result side.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*BITWIDTH-1:0] dividend,
  input  logic [BITWIDTH-1:0]   divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*BITWIDTH-1:0] quotient,
  output logic [BITWIDTH-1:0]   remainder,
  output logic                  div_by_zero
);

  localparam int DW = 2 * BITWIDTH;
  localparam int CW = cnt_width(BITWIDTH);

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [BITWIDTH-1:0] dvs_q;
  logic [DW-1:0]       quot_reg;
  logic [BITWIDTH:0]   prem;
  logic [BITWIDTH:0]   prem_nxt;
  logic                q_bit;
  logic                accept;
  logic                last_step;
  logic                dvs_zero;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign dvs_zero  = (divisor == '0);
  assign last_step = (cnt == CW'(1));

  seq_divider_div_step #(
    .BITWIDTH (BITWIDTH)
  ) u_step (
    .partial_rem (prem),
    .din_bit     (quot_reg[DW-1]),
    .divisor     (dvs_q),
    .new_rem     (prem_nxt),
    .q_bit       (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = dvs_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_step) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Working registers and the result registers; results only change at the
  // end of an operation (or a zero-divisor accept), so they stay stable in DONE
  // and keep the last value through IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt         <= '0;
      dvs_q       <= '0;
      quot_reg    <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvs_q       <= divisor;
      quot_reg    <= dividend;
      prem        <= '0;
      cnt         <= CW'(DW);
      div_by_zero <= dvs_zero;
      if (dvs_zero) begin
        quotient  <= '1;
        remainder <= '0;
      end
    end else if (state == ST_RUN) begin
      quot_reg <= {quot_reg[DW-2:0], q_bit};
      prem     <= prem_nxt;
      cnt      <= cnt - CW'(1);
      if (last_step) begin
        quotient  <= {quot_reg[DW-2:0], q_bit};
        remainder <= prem_nxt[BITWIDTH-1:0];
      end
    end
  end

endmodule
